// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, IR field positions,
// sequencer state encoding and the decoded-instruction bundle.
package cpu_pkg;

    // IR field positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_BIN,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle. master = sequencer, slave = datapath.
// Inputs: run, mem_rdy, ir. Outputs: strobes, register selects, status.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             mem_rdy;
    logic [31:0]      ir;

    logic             PCout;
    logic             incPC;
    logic             MARin;
    logic             read;
    logic             MDRin;
    logic             PCin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zin;
    logic             ZLowOut;
    logic             ZHighOut;
    logic             HIin;
    logic             LOin;
    logic             rout_en;
    logic [3:0]       rout_sel;
    logic             rin_en;
    logic [3:0]       rin_sel;
    logic [4:0]       opcode;
    logic             done;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, mem_rdy, ir,
        output PCout, incPC, MARin, read, MDRin, PCin, MDRout, IRin,
               Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
               rout_en, rout_sel, rin_en, rin_sel, opcode,
               done, busy, halted, illegal, instr_count
    );

    modport slave (
        output run, mem_rdy, ir,
        input  PCout, incPC, MARin, read, MDRin, PCin, MDRout, IRin,
               Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
               rout_en, rout_sel, rin_en, rin_sel, opcode,
               done, busy, halted, illegal, instr_count
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational IR decoder: instruction class plus register fields.
// Ports: ir_i (IR contents) -> dec_o (class, opcode, Ra, Rb, Rc).
module instr_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    logic unused_ir;
    assign unused_ir = ^ir_i[RC_LO-1:0];

    always_comb begin
        dec_o.op = ir_i[OP_HI:OP_LO];
        dec_o.ra = ir_i[RA_HI:RA_LO];
        dec_o.rb = ir_i[RB_HI:RB_LO];
        dec_o.rc = ir_i[RC_HI:RC_LO];
        unique case (ir_i[OP_HI:OP_LO])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                dec_o.cls = C_BIN;
            OP_MUL, OP_DIV:
                dec_o.cls = C_MULDIV;
            OP_NEG, OP_NOT:
                dec_o.cls = C_UNARY;
            OP_NOP:
                dec_o.cls = C_NOP;
            OP_HALT:
                dec_o.cls = C_HALT;
            default:
                dec_o.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer with retired-instruction counter.
// Ports: clock, clear (sync reset), bus (control_sequencer_if.master).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             done_c;
    dec_t             dec;

    instr_decode u_dec (
        .ir_i  (bus.ir),
        .dec_o (dec)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_rdy) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (dec.cls == C_HALT) ? S_HALT : S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = S_T6;
            S_T6:   state_d = S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Final T-state of any instruction chains or idles on run.
        if (done_c && dec.cls != C_HALT)
            state_d = bus.run ? S_T0 : S_IDLE;
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.incPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.rout_en  = 1'b0;
        bus.rout_sel = 4'd0;
        bus.rin_en   = 1'b0;
        bus.rin_sel  = 4'd0;
        bus.opcode   = 5'd0;
        done_c       = 1'b0;
        unique case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.incPC = 1'b1;
                bus.MARin = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.read  = 1'b1;
                bus.MDRin = 1'b1;
                bus.PCin  = bus.mem_rdy;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                unique case (dec.cls)
                    C_BIN, C_MULDIV: begin
                        bus.rout_en  = 1'b1;
                        bus.rout_sel = dec.rb;
                        bus.Yin      = 1'b1;
                    end
                    C_UNARY: begin
                        bus.rout_en  = 1'b1;
                        bus.rout_sel = dec.rb;
                        bus.opcode   = dec.op;
                        bus.Zin      = 1'b1;
                    end
                    default: done_c = 1'b1;
                endcase
            end
            S_T4: begin
                unique case (dec.cls)
                    C_BIN, C_MULDIV: begin
                        bus.rout_en  = 1'b1;
                        bus.rout_sel = dec.rc;
                        bus.opcode   = dec.op;
                        bus.Zin      = 1'b1;
                    end
                    C_UNARY: begin
                        bus.ZLowOut = 1'b1;
                        bus.rin_en  = 1'b1;
                        bus.rin_sel = dec.ra;
                        done_c      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                if (dec.cls == C_MULDIV) begin
                    bus.ZLowOut = 1'b1;
                    bus.LOin    = 1'b1;
                end else begin
                    bus.ZLowOut = 1'b1;
                    bus.rin_en  = 1'b1;
                    bus.rin_sel = dec.ra;
                    done_c      = 1'b1;
                end
            end
            S_T6: begin
                bus.ZHighOut = 1'b1;
                bus.HIin     = 1'b1;
                done_c       = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, done_c};
        ill_d = ill_q | (state_q == S_T3 && dec.cls == C_ILLEGAL);
    end

    assign bus.done        = done_c;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.illegal     = ill_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clock  in  1  sole clock; all state changes on the rising edge.
REQ-003 clear  in  1  reset, synchronous, active-high.
REQ-004 run  in  1  level; permits instruction fetch to start from IDLE or to chain after done.
REQ-005 mem_rdy  in  1  memory read data valid on Mdatain this cycle.
REQ-006 ir  in  32  datapath IR contents, valid from T3 onward; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-007 PCout, incPC, MARin, read, MDRin, PCin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin  out  1 each  datapath strobes.
REQ-008 rout_en / rout_sel  out  1 / 4  drive general register rout_sel onto the bus.
REQ-009 rin_en / rin_sel  out  1 / 4  load general register rin_sel from the bus.
REQ-010 opcode  out  5  ALU operation select.
REQ-011 done  out  1  one-cycle pulse in the final T-state of each instruction.
REQ-012 busy  out  1  high in every state except IDLE and HALT.
REQ-013 halted  out  1  high in HALT.
REQ-014 illegal  out  1  sticky; set on an undefined opcode, cleared only by clear.
REQ-015 instr_count  out  CNT_W  instructions retired.

Function
REQ-016 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; outputs are Moore (decoded from state and ir only) except as stated.
REQ-017 IDLE: all strobes 0; run=1 -> T0, else stay in IDLE.
REQ-018 T0: PCout, MARin, incPC, Zin = 1; -> T1.
REQ-019 T1: read, MDRin = 1 every cycle; mem_rdy=0 -> stay in T1; mem_rdy=1 -> PCin=1 in that cycle; -> T2.
REQ-020 T2: MDRout, IRin = 1; -> T3.
REQ-021 Binary ALU ops (ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011): T3 rout Rb, Yin; T4 rout Rc, opcode=ir[31:27], Zin; T5 ZLowOut, rin Ra, done.
REQ-022 MUL 01111 / DIV 10000: T3 and T4 as binary ops; T5 ZLowOut, LOin; T6 ZHighOut, HIin, done.
REQ-023 Unary ops (NEG 10001, NOT 10010): T3 rout Rb, opcode, Zin; T4 ZLowOut, rin Ra, done.
REQ-024 NOP 11010: done in T3; no register or Z strobes.
REQ-025 HALT 11011: T3 -> HALT with done=1 in T3; HALT holds all strobes at 0 and ignores run until clear.
REQ-026 Any other opcode: treated as NOP; illegal set at the T3 edge.
REQ-027 After a done cycle: run=1 -> T0, else IDLE; run is sampled only in IDLE and done cycles.
REQ-028 opcode output holds 5'b00000 outside T3/T4; rin_sel and rout_sel read 0 whenever their enable is 0.
REQ-029 instr_count increments by 1 on every done cycle (including NOP, HALT, illegal) and wraps from all-ones to 0.
REQ-030 No bus conflict: at most one of PCout, MDRout, ZLowOut, ZHighOut, rout_en is high in any cycle.

Reset
REQ-031 clear=1 at an edge, in any state (including T1 mid-wait and HALT), -> IDLE; all outputs 0; instr_count 0; illegal 0.
REQ-032 clear has priority over run and mem_rdy.

Structure
REQ-033 Package cpu_pkg holds the opcode constants, state encoding and ir field positions; the datapath and this block share it.
REQ-034 One combinational sub-module, instr_decode, maps ir to {class: BIN, MULDIV, UNARY, NOP, HALT, ILLEGAL; Ra; Rb; Rc}; the sequencer FSM and counter live in control_sequencer.

Verification
REQ-035 ir=0x1A1B8000 (ADD R4,R3,R7), mem_rdy=1 in T1 -> 6 cycles T0..T5; T3 rout_sel=3 + Yin; T4 rout_sel=7 + opcode=00011 + Zin; T5 rin_sel=4 + done; instr_count=1.
REQ-036 SHR (opcode 01001) with mem_rdy held 0 for 3 cycles -> T1 persists 4 cycles with read=MDRin=1; PCin only in the last; total 9 cycles to done.
REQ-037 MUL with run held 1 for two instructions -> T6 has ZHighOut+HIin+done; next cycle is T0; instr_count=2.
REQ-038 ir opcode 11111 -> illegal=1 after T3, done in T3; subsequent ADD still executes; illegal stays 1.
REQ-039 clear asserted in T4 of ADD -> next cycle IDLE, all strobes 0, instr_count=0; HALT opcode -> halted=1, run ignored until clear.
REQ-040 Counter preloaded via 2^CNT_W-1 done pulses (CNT_W=4: 15 NOPs) -> next done yields instr_count=0.
